// File: rtl/cpu_control_unit.sv
// Multi-cycle Moore control unit for the 16-bit CPU datapath.
// Sequences fetch/decode/execute and latches ALU flags after ALU ops.
module cpu_control_unit #(
    parameter int OPC_W = 7,
    parameter int ST_W  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [OPC_W-1:0] opc,
    input  logic [2:0]       opd1,
    input  logic [2:0]       opd2,
    input  logic [2:0]       opd3,
    input  logic             C,
    input  logic             V,
    input  logic             S,
    input  logic             Z_det,
    output logic             ldPC,
    output logic             ldIR,
    output logic             ldMAR,
    output logic             rd_mem,
    output logic             wr_mem,
    output logic             ldtmp,
    output logic             ldMDRZ,
    output logic             ldMDRdata,
    output logic             wr_reg,
    output logic             rd_reg,
    output logic             ldALU,
    output logic             ldXPC,
    output logic             ldYPC,
    output logic             ldXtmp,
    output logic             ldYtmp,
    output logic             ldXreg,
    output logic             ldYreg,
    output logic             ldXmem,
    output logic             ldYmem,
    output logic             ldXtmp2,
    output logic             ldYtmp2,
    output logic [2:0]       wr_regA,
    output logic [2:0]       rd_regA,
    output logic [2:0]       fsel,
    output logic [3:0]       flags,
    output logic [ST_W-1:0]  state,
    output logic             halted,
    output logic             illegal
);

    typedef enum logic [ST_W-1:0] {
        IDLE = 0,  F0 = 1,  F1 = 2,  F2 = 3,  F3 = 4,  DEC = 5,
        A0   = 6,  A1 = 7,  L0 = 8,  L1 = 9,  L2 = 10, L3 = 11,
        S0   = 12, S1 = 13, S2 = 14, B0 = 15, B1 = 16, HALT = 17
    } state_t;

    localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_NEG  = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_MOV  = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(7);
    localparam logic [OPC_W-1:0] OP_ST   = OPC_W'(8);
    localparam logic [OPC_W-1:0] OP_BZ   = OPC_W'(9);
    localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(127);

    state_t     r_state;
    logic [3:0] r_flags;
    logic       w_alu;
    logic       w_legal;
    logic [2:0] w_fsel_a1;

    assign w_alu   = (opc >= OP_ADD) && (opc <= OP_OR);
    assign w_legal = (opc <= OP_BZ) || (opc == OP_HALT);

    always_comb begin
        w_fsel_a1 = 3'd6;
        case (opc)
            OP_ADD:  w_fsel_a1 = 3'd0;
            OP_SUB:  w_fsel_a1 = 3'd1;
            OP_AND:  w_fsel_a1 = 3'd2;
            OP_OR:   w_fsel_a1 = 3'd3;
            OP_NEG:  w_fsel_a1 = 3'd4;
            default: w_fsel_a1 = 3'd6;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_flags <= 4'b0000;
        end else begin
            case (r_state)
                IDLE: if (run) r_state <= F0;
                F0:   r_state <= F1;
                F1:   r_state <= F2;
                F2:   r_state <= F3;
                F3:   r_state <= DEC;
                DEC: begin
                    unique case (1'b1)
                        w_alu:                        r_state <= A0;
                        opc == OP_NEG,
                        opc == OP_MOV:                r_state <= A1;
                        opc == OP_LD:                 r_state <= L0;
                        opc == OP_ST:                 r_state <= S0;
                        opc == OP_BZ:                 r_state <= r_flags[0] ? B0 : F0;
                        opc == OP_HALT:               r_state <= HALT;
                        default:                      r_state <= F0;
                    endcase
                end
                A0: r_state <= A1;
                A1: begin
                    r_state <= F0;
                    // MOV is a plain transfer and leaves the flags alone
                    if (w_alu || opc == OP_NEG)
                        r_flags <= {C, V, S, Z_det};
                end
                L0:      r_state <= L1;
                L1:      r_state <= L2;
                L2:      r_state <= L3;
                L3:      r_state <= F0;
                S0:      r_state <= S1;
                S1:      r_state <= S2;
                S2:      r_state <= F0;
                B0:      r_state <= B1;
                B1:      r_state <= F0;
                HALT:    r_state <= HALT;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        {ldPC, ldIR, ldMAR, rd_mem, wr_mem, ldtmp, ldMDRZ, ldMDRdata} = '0;
        {wr_reg, rd_reg, ldALU} = '0;
        {ldXPC, ldYPC, ldXtmp, ldYtmp, ldXreg, ldYreg} = '0;
        {ldXmem, ldYmem, ldXtmp2, ldYtmp2} = '0;
        wr_regA = 3'd0;
        rd_regA = 3'd0;
        fsel    = 3'd0;
        case (r_state)
            F0: ldYtmp2 = 1'b1;
            F1: begin
                ldXPC = 1'b1; fsel = 3'd6; ldALU = 1'b1; ldMAR = 1'b1;
            end
            F2: begin
                rd_mem = 1'b1; ldXPC = 1'b1; ldALU = 1'b1; ldPC = 1'b1;
            end
            F3: ldIR = 1'b1;
            A0: begin
                rd_reg = 1'b1; rd_regA = opd3; ldYreg = 1'b1;
            end
            A1: begin
                rd_reg = 1'b1; rd_regA = opd2; ldXreg = 1'b1;
                fsel = w_fsel_a1; ldALU = 1'b1;
                wr_reg = 1'b1; wr_regA = opd1;
            end
            L0, S0: begin
                rd_reg = 1'b1; rd_regA = opd2; ldXreg = 1'b1;
                fsel = 3'd6; ldALU = 1'b1; ldMAR = 1'b1;
            end
            L1: rd_mem = 1'b1;
            L2: ldMDRdata = 1'b1;
            L3: begin
                ldXmem = 1'b1; fsel = 3'd6; ldALU = 1'b1;
                wr_reg = 1'b1; wr_regA = opd1;
            end
            S1: begin
                rd_reg = 1'b1; rd_regA = opd3; ldXreg = 1'b1;
                fsel = 3'd6; ldALU = 1'b1; ldMDRZ = 1'b1;
            end
            S2: wr_mem = 1'b1;
            B0: ldYPC = 1'b1;
            B1: begin
                rd_reg = 1'b1; rd_regA = opd1; ldXreg = 1'b1;
                ldALU = 1'b1; ldPC = 1'b1;
            end
            default: ;
        endcase
    end

    assign flags   = r_flags;
    assign state   = r_state;
    assign halted  = (r_state == HALT);
    assign illegal = (r_state == DEC) && !w_legal;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Scoreboard bench for cpu_control_unit: stimulus queues expected
// per-cycle outputs, a monitor pops and compares them at the falling edge.
module tb_cpu_control_unit;

    logic       clk, reset, run;
    logic [6:0] opc;
    logic [2:0] opd1, opd2, opd3;
    logic       C, V, S, Z_det;
    logic ldPC, ldIR, ldMAR, rd_mem, wr_mem, ldtmp, ldMDRZ, ldMDRdata;
    logic wr_reg, rd_reg, ldALU;
    logic ldXPC, ldYPC, ldXtmp, ldYtmp, ldXreg, ldYreg;
    logic ldXmem, ldYmem, ldXtmp2, ldYtmp2;
    logic [2:0] wr_regA, rd_regA, fsel;
    logic [3:0] flags;
    logic [4:0] state;
    logic       halted, illegal;

    cpu_control_unit #(.OPC_W(7), .ST_W(5)) dut (
        .clk(clk), .reset(reset), .run(run), .opc(opc),
        .opd1(opd1), .opd2(opd2), .opd3(opd3),
        .C(C), .V(V), .S(S), .Z_det(Z_det),
        .ldPC(ldPC), .ldIR(ldIR), .ldMAR(ldMAR), .rd_mem(rd_mem),
        .wr_mem(wr_mem), .ldtmp(ldtmp), .ldMDRZ(ldMDRZ),
        .ldMDRdata(ldMDRdata), .wr_reg(wr_reg), .rd_reg(rd_reg),
        .ldALU(ldALU), .ldXPC(ldXPC), .ldYPC(ldYPC), .ldXtmp(ldXtmp),
        .ldYtmp(ldYtmp), .ldXreg(ldXreg), .ldYreg(ldYreg),
        .ldXmem(ldXmem), .ldYmem(ldYmem), .ldXtmp2(ldXtmp2),
        .ldYtmp2(ldYtmp2), .wr_regA(wr_regA), .rd_regA(rd_regA),
        .fsel(fsel), .flags(flags), .state(state),
        .halted(halted), .illegal(illegal)
    );

    localparam logic [20:0] B_PC    = 21'd1 << 20;
    localparam logic [20:0] B_IR    = 21'd1 << 19;
    localparam logic [20:0] B_MAR   = 21'd1 << 18;
    localparam logic [20:0] B_RDM   = 21'd1 << 17;
    localparam logic [20:0] B_WRM   = 21'd1 << 16;
    localparam logic [20:0] B_MDRZ  = 21'd1 << 14;
    localparam logic [20:0] B_MDRD  = 21'd1 << 13;
    localparam logic [20:0] B_WRR   = 21'd1 << 12;
    localparam logic [20:0] B_RDR   = 21'd1 << 11;
    localparam logic [20:0] B_ALU   = 21'd1 << 10;
    localparam logic [20:0] B_XPC   = 21'd1 << 9;
    localparam logic [20:0] B_YPC   = 21'd1 << 8;
    localparam logic [20:0] B_XREG  = 21'd1 << 5;
    localparam logic [20:0] B_YREG  = 21'd1 << 4;
    localparam logic [20:0] B_XMEM  = 21'd1 << 3;
    localparam logic [20:0] B_YTMP2 = 21'd1 << 0;
    localparam logic [20:0] B_NONE  = 21'd0;

    typedef struct {
        string       nm;
        logic [40:0] v;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         failures = 0;
    logic [3:0] expf;
    event       ev_smp;

    logic [40:0] act;
    assign act = {state, halted, illegal, flags, wr_regA, rd_regA, fsel,
                  ldPC, ldIR, ldMAR, rd_mem, wr_mem, ldtmp, ldMDRZ,
                  ldMDRdata, wr_reg, rd_reg, ldALU, ldXPC, ldYPC, ldXtmp,
                  ldYtmp, ldXreg, ldYreg, ldXmem, ldYmem, ldXtmp2, ldYtmp2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk or ev_smp);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (act !== e.v) begin
                    failures++;
                    $display("FAIL %s at %0t: got=%h want=%h",
                             e.nm, $time, act, e.v);
                end
            end
        end
    end

    function automatic logic [40:0] mk(input logic [4:0] st,
                                       input logic [20:0] sb,
                                       input logic [2:0] wa,
                                       input logic [2:0] ra,
                                       input logic [2:0] fs,
                                       input logic il,
                                       input logic [3:0] fl);
        return {st, (st == 5'd17), il, fl, wa, ra, fs, sb};
    endfunction

    task automatic push(input string nm, input logic [4:0] st,
                        input logic [20:0] sb, input logic [2:0] wa,
                        input logic [2:0] ra, input logic [2:0] fs,
                        input logic il);
        exp_t e;
        e.nm = nm;
        e.v  = mk(st, sb, wa, ra, fs, il, expf);
        q.push_back(e);
    endtask

    task automatic cyc(input string nm, input logic [4:0] st,
                       input logic [20:0] sb, input logic [2:0] wa,
                       input logic [2:0] ra, input logic [2:0] fs,
                       input logic il);
        @(posedge clk);
        #1;
        push(nm, st, sb, wa, ra, fs, il);
    endtask

    task automatic fetch(input logic [6:0] o, input logic [2:0] a,
                         input logic [2:0] b, input logic [2:0] c,
                         input logic cc, input logic vv,
                         input logic ss, input logic zz,
                         input logic il);
        cyc("F0", 5'd1, B_YTMP2, 3'd0, 3'd0, 3'd0, 1'b0);
        opc = o; opd1 = a; opd2 = b; opd3 = c;
        C = cc; V = vv; S = ss; Z_det = zz;
        run = 1'b0;
        cyc("F1", 5'd2, B_XPC | B_ALU | B_MAR, 3'd0, 3'd0, 3'd6, 1'b0);
        cyc("F2", 5'd3, B_RDM | B_XPC | B_ALU | B_PC,
            3'd0, 3'd0, 3'd0, 1'b0);
        cyc("F3", 5'd4, B_IR, 3'd0, 3'd0, 3'd0, 1'b0);
        cyc("DEC", 5'd5, B_NONE, 3'd0, 3'd0, 3'd0, il);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, time=%0t", $time);
        $fatal(1);
    end

    initial begin
        reset = 1'b0; run = 1'b0; opc = '0;
        opd1 = '0; opd2 = '0; opd3 = '0;
        C = 1'b0; V = 1'b0; S = 1'b0; Z_det = 1'b0;
        expf = 4'b0000;

        cyc("rst", 5'd0, B_NONE, 3'd0, 3'd0, 3'd0, 1'b0);
        reset = 1'b1;
        repeat (10) cyc("idle", 5'd0, B_NONE, 3'd0, 3'd0, 3'd0, 1'b0);
        run = 1'b1;

        // ADD R3 = R1 + R2 with carry out
        fetch(7'd1, 3'd3, 3'd1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("add_A0", 5'd6, B_RDR | B_YREG, 3'd0, 3'd2, 3'd0, 1'b0);
        cyc("add_A1", 5'd7, B_RDR | B_XREG | B_ALU | B_WRR,
            3'd3, 3'd1, 3'd0, 1'b0);
        expf = 4'b1000;

        // LD R5 = mem[R4]; flags must not move
        fetch(7'd7, 3'd5, 3'd4, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("ld_L0", 5'd8, B_RDR | B_XREG | B_ALU | B_MAR,
            3'd0, 3'd4, 3'd6, 1'b0);
        cyc("ld_L1", 5'd9, B_RDM, 3'd0, 3'd0, 3'd0, 1'b0);
        cyc("ld_L2", 5'd10, B_MDRD, 3'd0, 3'd0, 3'd0, 1'b0);
        cyc("ld_L3", 5'd11, B_XMEM | B_ALU | B_WRR,
            3'd5, 3'd0, 3'd6, 1'b0);

        // SUB producing zero
        fetch(7'd2, 3'd1, 3'd2, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("sub_A0", 5'd6, B_RDR | B_YREG, 3'd0, 3'd3, 3'd0, 1'b0);
        cyc("sub_A1", 5'd7, B_RDR | B_XREG | B_ALU | B_WRR,
            3'd1, 3'd2, 3'd1, 1'b0);
        expf = 4'b0001;

        // BZ taken
        fetch(7'd9, 3'd6, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("bz_B0", 5'd15, B_YPC, 3'd0, 3'd0, 3'd0, 1'b0);
        cyc("bz_B1", 5'd16, B_RDR | B_XREG | B_ALU | B_PC,
            3'd0, 3'd6, 3'd0, 1'b0);

        // MOV keeps flags even with new ALU flags presented
        fetch(7'd6, 3'd2, 3'd7, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("mov_A1", 5'd7, B_RDR | B_XREG | B_ALU | B_WRR,
            3'd2, 3'd7, 3'd6, 1'b0);

        // NEG updates flags
        fetch(7'd5, 3'd4, 3'd5, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("neg_A1", 5'd7, B_RDR | B_XREG | B_ALU | B_WRR,
            3'd4, 3'd5, 3'd4, 1'b0);
        expf = 4'b0110;

        // BZ not taken: DEC straight back to F0
        fetch(7'd9, 3'd6, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // ST mem[R3] = R4
        fetch(7'd8, 3'd0, 3'd3, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("st_S0", 5'd12, B_RDR | B_XREG | B_ALU | B_MAR,
            3'd0, 3'd3, 3'd6, 1'b0);
        cyc("st_S1", 5'd13, B_RDR | B_XREG | B_ALU | B_MDRZ,
            3'd0, 3'd4, 3'd6, 1'b0);
        cyc("st_S2", 5'd14, B_WRM, 3'd0, 3'd0, 3'd0, 1'b0);

        // AND and OR
        fetch(7'd3, 3'd1, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("and_A0", 5'd6, B_RDR | B_YREG, 3'd0, 3'd1, 3'd0, 1'b0);
        cyc("and_A1", 5'd7, B_RDR | B_XREG | B_ALU | B_WRR,
            3'd1, 3'd1, 3'd2, 1'b0);
        expf = 4'b0001;
        fetch(7'd4, 3'd7, 3'd6, 3'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("or_A0", 5'd6, B_RDR | B_YREG, 3'd0, 3'd5, 3'd0, 1'b0);
        cyc("or_A1", 5'd7, B_RDR | B_XREG | B_ALU | B_WRR,
            3'd7, 3'd6, 3'd3, 1'b0);
        expf = 4'b1110;

        // illegal opcode pulses once, then NOP
        fetch(7'h55, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        fetch(7'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // LD aborted by reset in L1
        fetch(7'd7, 3'd1, 3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("abort_L0", 5'd8, B_RDR | B_XREG | B_ALU | B_MAR,
            3'd0, 3'd2, 3'd6, 1'b0);
        cyc("abort_L1", 5'd9, B_RDM, 3'd0, 3'd0, 3'd0, 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        expf = 4'b0000;
        #1;
        push("async_rst", 5'd0, B_NONE, 3'd0, 3'd0, 3'd0, 1'b0);
        -> ev_smp;
        repeat (2) cyc("rst_hold", 5'd0, B_NONE, 3'd0, 3'd0, 3'd0, 1'b0);
        reset = 1'b1;
        repeat (3) cyc("idle2", 5'd0, B_NONE, 3'd0, 3'd0, 3'd0, 1'b0);
        run = 1'b1;

        // HALT holds regardless of run
        fetch(7'd127, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc("halt", 5'd17, B_NONE, 3'd0, 3'd0, 3'd0, 1'b0);
            run = ~run;
        end

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: pending=%0d want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
